sm4_key_sched_ctrl: RTL and testbench

- Sequencer for the SM4 key-expansion round datapath.
- Accepts a 128-bit master key and drives 32 round requests (round index plus 128-bit key state) into the datapath, one round in flight at a time.
- Feeds each returned 128-bit state back as the next round's input and stores the 32 round keys rk0..rk31 in an internal buffer.
- Serves the buffer to the cipher round engine through a registered read port, in forward order for encryption and reversed order for decryption.

---
 rtl/sm4_key_sched_ctrl.sv | 177 +++++++++++++++++
 tb/tb_sm4_key_sched_ctrl.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sm4_key_sched_ctrl.sv
// SM4 key-expansion sequencer: runs 32 datapath rounds and serves rk0..rk31.
// Define SM4_KEY_CACHE_EN to skip re-expansion of the last successful key.
module sm4_key_sched_ctrl #(
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned CNT_W   = 8
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_start,
    input  logic [127:0] i_key,
    output logic         o_busy,
    output logic         o_done,
    output logic         o_error,
    output logic         o_keys_valid,
    output logic         o_ke_valid,
    output logic [4:0]   o_ke_i,
    output logic [127:0] o_ke_key,
    input  logic         i_ke_valid,
    input  logic [31:0]  i_ke_rk,
    input  logic [127:0] i_ke_k,
    input  logic         i_rd_en,
    input  logic [4:0]   i_rd_idx,
    input  logic         i_rd_decrypt,
    output logic [31:0]  o_rd_data,
    output logic         o_rd_valid
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE,
        S_ERR
    } state_e;

    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

    state_e         state_q, state_d;
    logic [4:0]     round_q, round_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [127:0]   key_q, key_d;
    logic           err_q, err_d;
    logic           kv_q, kv_d;
    logic           buf_we;
    logic [31:0]    buf_q [32];
    logic           rd_valid_q;
    logic [31:0]    rd_data_q;
    logic [4:0]     rd_addr;

`ifdef SM4_KEY_CACHE_EN
    logic [127:0]   mk_q, mk_d;
    logic [127:0]   cache_q, cache_d;
`endif

    always_comb begin
        state_d = state_q;
        round_d = round_q;
        cnt_d   = cnt_q;
        key_d   = key_q;
        err_d   = err_q;
        kv_d    = kv_q;
        buf_we  = 1'b0;
`ifdef SM4_KEY_CACHE_EN
        mk_d    = mk_q;
        cache_d = cache_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    key_d   = i_key;
                    round_d = 5'd0;
                    err_d   = 1'b0;
`ifdef SM4_KEY_CACHE_EN
                    mk_d    = i_key;
                    if (kv_q && (i_key == cache_q)) begin
                        state_d = S_DONE;
                    end else begin
                        kv_d    = 1'b0;
                        state_d = S_ISSUE;
                    end
`else
                    kv_d    = 1'b0;
                    state_d = S_ISSUE;
`endif
                end
            end
            S_ISSUE: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                // A response in the timeout cycle still counts.
                if (i_ke_valid) begin
                    buf_we = 1'b1;
                    key_d  = i_ke_k;
                    if (round_q == 5'd31) begin
                        state_d = S_DONE;
                    end else begin
                        round_d = round_q + 5'd1;
                        state_d = S_ISSUE;
                    end
                end else if (cnt_q == TMO_LAST) begin
                    state_d = S_ERR;
                end
            end
            S_DONE: begin
                kv_d    = 1'b1;
`ifdef SM4_KEY_CACHE_EN
                cache_d = mk_q;
`endif
                state_d = S_IDLE;
            end
            S_ERR: begin
                err_d   = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            round_q <= 5'd0;
            cnt_q   <= '0;
            key_q   <= '0;
            err_q   <= 1'b0;
            kv_q    <= 1'b0;
`ifdef SM4_KEY_CACHE_EN
            mk_q    <= '0;
            cache_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            cnt_q   <= cnt_d;
            key_q   <= key_d;
            err_q   <= err_d;
            kv_q    <= kv_d;
`ifdef SM4_KEY_CACHE_EN
            mk_q    <= mk_d;
            cache_q <= cache_d;
`endif
        end
    end

    always_ff @(posedge i_clk) begin
        if (buf_we) begin
            buf_q[round_q] <= i_ke_rk;
        end
    end

    // 31 - idx equals the bitwise inverse for a 5-bit index.
    assign rd_addr = i_rd_decrypt ? ~i_rd_idx : i_rd_idx;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= i_rd_en && kv_q;
            rd_data_q  <= (i_rd_en && kv_q) ? buf_q[rd_addr] : 32'd0;
        end
    end

    assign o_busy       = (state_q != S_IDLE);
    assign o_done       = (state_q == S_DONE);
    assign o_error      = err_q;
    assign o_keys_valid = kv_q;
    assign o_ke_valid   = (state_q == S_ISSUE);
    assign o_ke_i       = round_q;
    assign o_ke_key     = key_q;
    assign o_rd_valid   = rd_valid_q;
    assign o_rd_data    = rd_data_q;

endmodule

// File: tb/tb_sm4_key_sched_ctrl.sv
// Scoreboard bench for sm4_key_sched_ctrl with a behavioural SM4 datapath.
// Honours SM4_KEY_CACHE_EN for the repeated-key scenario.
module tb_sm4_key_sched_ctrl;

    localparam int L = 4;
    localparam logic [127:0] FK = 128'hA3B1BAC656AA3350677D9197B27022DC;
    localparam logic [127:0] KEY1 = 128'h0123456789ABCDEFFEDCBA9876543210;

    localparam logic [7:0] SBOX [256] = '{
        8'hd6,8'h90,8'he9,8'hfe,8'hcc,8'he1,8'h3d,8'hb7,8'h16,8'hb6,8'h14,8'hc2,8'h28,8'hfb,8'h2c,8'h05,
        8'h2b,8'h67,8'h9a,8'h76,8'h2a,8'hbe,8'h04,8'hc3,8'haa,8'h44,8'h13,8'h26,8'h49,8'h86,8'h06,8'h99,
        8'h9c,8'h42,8'h50,8'hf4,8'h91,8'hef,8'h98,8'h7a,8'h33,8'h54,8'h0b,8'h43,8'hed,8'hcf,8'hac,8'h62,
        8'he4,8'hb3,8'h1c,8'ha9,8'hc9,8'h08,8'he8,8'h95,8'h80,8'hdf,8'h94,8'hfa,8'h75,8'h8f,8'h3f,8'ha6,
        8'h47,8'h07,8'ha7,8'hfc,8'hf3,8'h73,8'h17,8'hba,8'h83,8'h59,8'h3c,8'h19,8'he6,8'h85,8'h4f,8'ha8,
        8'h68,8'h6b,8'h81,8'hb2,8'h71,8'h64,8'hda,8'h8b,8'hf8,8'heb,8'h0f,8'h4b,8'h70,8'h56,8'h9d,8'h35,
        8'h1e,8'h24,8'h0e,8'h5e,8'h63,8'h58,8'hd1,8'ha2,8'h25,8'h22,8'h7c,8'h3b,8'h01,8'h21,8'h78,8'h87,
        8'hd4,8'h00,8'h46,8'h57,8'h9f,8'hd3,8'h27,8'h52,8'h4c,8'h36,8'h02,8'he7,8'ha0,8'hc4,8'hc8,8'h9e,
        8'hea,8'hbf,8'h8a,8'hd2,8'h40,8'hc7,8'h38,8'hb5,8'ha3,8'hf7,8'hf2,8'hce,8'hf9,8'h61,8'h15,8'ha1,
        8'he0,8'hae,8'h5d,8'ha4,8'h9b,8'h34,8'h1a,8'h55,8'had,8'h93,8'h32,8'h30,8'hf5,8'h8c,8'hb1,8'he3,
        8'h1d,8'hf6,8'he2,8'h2e,8'h82,8'h66,8'hca,8'h60,8'hc0,8'h29,8'h23,8'hab,8'h0d,8'h53,8'h4e,8'h6f,
        8'hd5,8'hdb,8'h37,8'h45,8'hde,8'hfd,8'h8e,8'h2f,8'h03,8'hff,8'h6a,8'h72,8'h6d,8'h6c,8'h5b,8'h51,
        8'h8d,8'h1b,8'haf,8'h92,8'hbb,8'hdd,8'hbc,8'h7f,8'h11,8'hd9,8'h5c,8'h41,8'h1f,8'h10,8'h5a,8'hd8,
        8'h0a,8'hc1,8'h31,8'h88,8'ha5,8'hcd,8'h7b,8'hbd,8'h2d,8'h74,8'hd0,8'h12,8'hb8,8'he5,8'hb4,8'hb0,
        8'h89,8'h69,8'h97,8'h4a,8'h0c,8'h96,8'h77,8'h7e,8'h65,8'hb9,8'hf1,8'h09,8'hc5,8'h6e,8'hc6,8'h84,
        8'h18,8'hf0,8'h7d,8'hec,8'h3a,8'hdc,8'h4d,8'h20,8'h79,8'hee,8'h5f,8'h3e,8'hd7,8'hcb,8'h39,8'h48
    };

    logic         i_clk = 1'b0;
    logic         i_rst = 1'b1;
    logic         i_start = 1'b0;
    logic [127:0] i_key = '0;
    logic         o_busy, o_done, o_error, o_keys_valid;
    logic         o_ke_valid;
    logic [4:0]   o_ke_i;
    logic [127:0] o_ke_key;
    logic         i_ke_valid = 1'b0;
    logic [31:0]  i_ke_rk = '0;
    logic [127:0] i_ke_k = '0;
    logic         i_rd_en = 1'b0;
    logic [4:0]   i_rd_idx = '0;
    logic         i_rd_decrypt = 1'b0;
    logic [31:0]  o_rd_data;
    logic         o_rd_valid;

    sm4_key_sched_ctrl #(.TIMEOUT(64), .CNT_W(8)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_key(i_key),
        .o_busy(o_busy), .o_done(o_done), .o_error(o_error),
        .o_keys_valid(o_keys_valid), .o_ke_valid(o_ke_valid),
        .o_ke_i(o_ke_i), .o_ke_key(o_ke_key), .i_ke_valid(i_ke_valid),
        .i_ke_rk(i_ke_rk), .i_ke_k(i_ke_k), .i_rd_en(i_rd_en),
        .i_rd_idx(i_rd_idx), .i_rd_decrypt(i_rd_decrypt),
        .o_rd_data(o_rd_data), .o_rd_valid(o_rd_valid)
    );

    always #5 i_clk = ~i_clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int ke_cnt = 0;
    int lat_fix = 0;
    bit mute_en = 1'b0;
    int mute_rd = 0;
    int start_cyc = 0;
    logic rd_seen = 1'b0;

    logic [132:0] ke_q [$];
    int           done_q [$];
    logic [32:0]  rd_q [$];

    logic [31:0] ref_k [36];
    logic [31:0] pend_rk [32];
    logic [31:0] sched_rk [32];
    bit          exp_kv = 1'b0;

    always @(posedge i_clk) cyc <= cyc + 1;
    always @(posedge i_clk) rd_seen <= i_rd_en;

    function automatic logic [31:0] tp(input logic [31:0] a);
        logic [31:0] b;
        b = {SBOX[a[31:24]], SBOX[a[23:16]], SBOX[a[15:8]], SBOX[a[7:0]]};
        return b ^ ((b << 13) | (b >> 19)) ^ ((b << 23) | (b >> 9));
    endfunction

    function automatic logic [31:0] ck(input int i);
        logic [31:0] c;
        c = '0;
        for (int j = 0; j < 4; j++) c[31-8*j -: 8] = 8'(((4*i + j) * 7) % 256);
        return c;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic note_fail(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: got no event expected event", nm);
    endtask

    // Whole-schedule reference: K[0..35] from MK xor FK, rk[i] = K[i+4].
    task automatic build_ref(input logic [127:0] mk);
        logic [127:0] s;
        s = mk ^ FK;
        for (int j = 0; j < 4; j++) ref_k[j] = s[127-32*j -: 32];
        for (int i = 0; i < 32; i++)
            ref_k[i+4] = ref_k[i] ^ tp(ref_k[i+1] ^ ref_k[i+2] ^ ref_k[i+3] ^ ck(i));
        for (int i = 0; i < 32; i++) pend_rk[i] = ref_k[i+4];
    endtask

    task automatic push_ke(input logic [127:0] mk, input int n);
        build_ref(mk);
        for (int i = 0; i < n; i++) begin
            if (i == 0) ke_q.push_back({5'd0, mk});
            else ke_q.push_back({5'(i), ref_k[i], ref_k[i+1], ref_k[i+2], ref_k[i+3]});
        end
    endtask

    // Behavioural round datapath with fixed or random latency.
    initial begin
        int dp_cnt;
        logic [4:0] rq_i;
        logic [127:0] rq_k, s;
        logic [31:0] w;
        dp_cnt = -1;
        rq_i = '0;
        rq_k = '0;
        forever begin
            @(posedge i_clk);
            if (i_rst) begin
                dp_cnt = -1;
            end else if (o_ke_valid) begin
                rq_i = o_ke_i;
                rq_k = o_ke_key;
                if (!(mute_en && int'(o_ke_i) == mute_rd))
                    dp_cnt = (lat_fix > 0 ? lat_fix : int'($urandom_range(1, 6))) - 1;
            end else if (dp_cnt > 0) begin
                dp_cnt--;
            end
            #1;
            if (dp_cnt == 0) begin
                s = (rq_i == 5'd0) ? (rq_k ^ FK) : rq_k;
                w = s[127:96] ^ tp(s[95:64] ^ s[63:32] ^ s[31:0] ^ ck(int'(rq_i)));
                i_ke_rk = w;
                i_ke_k = {s[95:0], w};
                i_ke_valid = 1'b1;
                dp_cnt = -1;
            end else begin
                i_ke_rk = $urandom;
                i_ke_k = {$urandom, $urandom, $urandom, $urandom};
                // Stray responses while idle must be ignored.
                i_ke_valid = !o_busy && ($urandom_range(0, 3) == 0);
            end
        end
    end

    always @(negedge i_clk) begin
        logic [132:0] e;
        logic [32:0] r;
        int d;
        if (o_ke_valid) begin
            ke_cnt++;
            if (ke_q.size() == 0) begin
                note_fail("ke_unexpected");
            end else begin
                e = ke_q.pop_front();
                chk("ke_i", 128'(o_ke_i), 128'(e[132:128]));
                chk("ke_key", o_ke_key, e[127:0]);
            end
        end
        if (o_done) begin
            if (done_q.size() == 0) begin
                note_fail("done_unexpected");
            end else begin
                d = done_q.pop_front();
                if (d >= 0) chk("done_cycle", 128'(cyc), 128'(d));
            end
        end
        if (rd_seen) begin
            if (rd_q.size() == 0) begin
                note_fail("rd_queue_empty");
            end else begin
                r = rd_q.pop_front();
                chk("rd_valid", 128'(o_rd_valid), 128'(r[32]));
                chk("rd_data", 128'(o_rd_data), 128'(r[31:0]));
            end
        end else begin
            chk("rd_idle_valid", 128'(o_rd_valid), 128'(0));
        end
    end

    // done_off >= 0: exact done cycle relative to start; -1: any cycle; -2: none.
    task automatic pulse_start(input logic [127:0] k, input int done_off);
        @(posedge i_clk);
        #1;
        i_start = 1'b1;
        i_key = k;
        start_cyc = cyc;
        if (done_off >= 0) done_q.push_back(start_cyc + done_off);
        else if (done_off == -1) done_q.push_back(-1);
        @(posedge i_clk);
        #1;
        i_start = 1'b0;
        i_key = '0;
    endtask

    task automatic wait_idle(input int bound);
        int n;
        n = 0;
        do begin
            @(negedge i_clk);
            n++;
        end while (o_busy && n < bound);
        if (o_busy) note_fail("idle_timeout");
    endtask

    task automatic wait_round(input int r, input int bound);
        int n;
        n = 0;
        do begin
            @(negedge i_clk);
            n++;
        end while (!(o_ke_valid && int'(o_ke_i) == r) && n < bound);
        if (!(o_ke_valid && int'(o_ke_i) == r)) note_fail("round_wait_timeout");
    endtask

    task automatic rd_chk(input int idx, input bit dec, input bit ev, input logic [31:0] ed);
        @(posedge i_clk);
        #1;
        i_rd_en = 1'b1;
        i_rd_idx = 5'(idx);
        i_rd_decrypt = dec;
        rd_q.push_back({ev, ed});
        @(posedge i_clk);
        #1;
        i_rd_en = 1'b0;
    endtask

    task automatic rd_random(input int n);
        int idx;
        bit dec;
        for (int i = 0; i < n; i++) begin
            idx = $urandom_range(0, 31);
            dec = 1'($urandom_range(0, 1));
            rd_chk(idx, dec, exp_kv, exp_kv ? sched_rk[dec ? 31 - idx : idx] : 32'd0);
        end
    endtask

    // Counting the start cycle as cycle 1, o_done lands on cycle 32(L+1)+2.
    task automatic run(input logic [127:0] k, input bit exact);
        ke_cnt = 0;
        push_ke(k, 32);
        pulse_start(k, exact ? 32 * (L + 1) + 1 : -1);
        wait_idle(3000);
        chk("ke_pulses", 128'(ke_cnt), 128'(32));
        chk("keys_valid", 128'(o_keys_valid), 128'(1));
        chk("error_clear", 128'(o_error), 128'(0));
        for (int i = 0; i < 32; i++) sched_rk[i] = pend_rk[i];
        exp_kv = 1'b1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [127:0] ka, kb, kc, kd, ke, kf;
        ka = {$urandom, $urandom, $urandom, $urandom};
        kb = {$urandom, $urandom, $urandom, $urandom};
        kc = {$urandom, $urandom, $urandom, $urandom};
        kd = {$urandom, $urandom, $urandom, $urandom};
        ke = {$urandom, $urandom, $urandom, $urandom};
        kf = {$urandom, $urandom, $urandom, $urandom};

        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        chk("reset_flags", 128'({o_busy, o_done, o_error, o_keys_valid, o_ke_valid}), 128'(0));
        chk("reset_ke", {o_ke_i, o_ke_key[122:0]} | 128'(o_ke_key[127:123]), 128'(0));
        chk("reset_rd", 128'({o_rd_valid, o_rd_data}), 128'(0));
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;

        // Known-answer expansion at fixed latency.
        lat_fix = L;
        run(KEY1, 1'b1);
        chk("busy_after_done", 128'(o_busy), 128'(0));
        rd_chk(0, 1'b0, 1'b1, 32'hF12186F9);
        rd_chk(31, 1'b0, 1'b1, 32'h9124A012);
        rd_chk(0, 1'b1, 1'b1, 32'h9124A012);
        rd_chk(31, 1'b1, 1'b1, 32'hF12186F9);
        rd_random(8);

        // Datapath silent at round 5.
        lat_fix = 0;
        mute_en = 1'b1;
        mute_rd = 5;
        ke_cnt = 0;
        push_ke(ka, 6);
        pulse_start(ka, -2);
        wait_idle(3000);
        chk("timeout_error", 128'(o_error), 128'(1));
        chk("timeout_kv", 128'(o_keys_valid), 128'(0));
        chk("timeout_pulses", 128'(ke_cnt), 128'(6));
        exp_kv = 1'b0;
        rd_random(3);
        mute_en = 1'b0;

        // Start ignored while busy.
        ke_cnt = 0;
        push_ke(kb, 32);
        pulse_start(kb, -1);
        @(negedge i_clk);
        chk("error_cleared_on_start", 128'(o_error), 128'(0));
        wait_round(10, 1000);
        pulse_start(kc, -2);
        wait_idle(3000);
        chk("busy_start_pulses", 128'(ke_cnt), 128'(32));
        chk("busy_start_kv", 128'(o_keys_valid), 128'(1));
        for (int i = 0; i < 32; i++) sched_rk[i] = pend_rk[i];
        exp_kv = 1'b1;
        rd_random(6);

        // Reset in the middle of round 20.
        push_ke(kd, 32);
        pulse_start(kd, -1);
        wait_round(20, 1000);
        @(posedge i_clk);
        #1;
        i_rst = 1'b1;
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        @(negedge i_clk);
        chk("abort_flags", 128'({o_busy, o_done, o_error, o_keys_valid, o_ke_valid}), 128'(0));
        chk("abort_ke_i", 128'(o_ke_i), 128'(0));
        chk("abort_ke_key", o_ke_key, 128'(0));
        chk("abort_rd", 128'({o_rd_valid, o_rd_data}), 128'(0));
        ke_q.delete();
        done_q.delete();
        exp_kv = 1'b0;
        rd_random(2);
        run(ke, 1'b0);
        rd_random(6);

        // Restart with the same key.
`ifdef SM4_KEY_CACHE_EN
        ke_cnt = 0;
        pulse_start(ke, 1);
        wait_idle(100);
        chk("cache_pulses", 128'(ke_cnt), 128'(0));
        chk("cache_kv", 128'(o_keys_valid), 128'(1));
`else
        run(ke, 1'b0);
`endif
        rd_random(6);
        run(kf, 1'b0);
        rd_random(6);

        repeat (3) @(negedge i_clk);
        chk("ke_queue_drained", 128'(ke_q.size()), 128'(0));
        chk("done_queue_drained", 128'(done_q.size()), 128'(0));
        chk("rd_queue_drained", 128'(rd_q.size()), 128'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
